acc_seq_ctrl: RTL and testbench

- Sequencer for the signed accumulator in the LDPC node-update datapath: per node, fetches DEG edge messages from message memory, streams them into the accumulator with the correct init/valid timing, and presents each node sum on a valid/ready output.
- Sits between the message RAM, one accumulator instance and the downstream node-update stage.
- Processes NODES nodes per start command.

---
 rtl/ldpc_pkg.sv | 21 ++
 rtl/acc_seq_ctrl_if.sv | 34 +++
 rtl/acc_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and constants for the LDPC node-update datapath sequencers.
// Used by acc_seq_ctrl and its bus interface.
package ldpc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        TAIL  = 2'd2,
        OUT   = 2'd3
    } seq_state_e;

    localparam logic [2:0] ACC_INIT_LOAD = 3'd1;
    localparam logic [2:0] ACC_INIT_NONE = 3'd0;
    localparam int         DW_DEF        = 16;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// Memory / accumulator / node-sum bus of the accumulator sequencer.
// master = sequencer side, slave = RAM, accumulator and downstream stage.
interface acc_seq_ctrl_if
    import ldpc_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = 6,
    parameter int NIW = 3
);
    logic                 o_mem_rd;
    logic [AW-1:0]        o_mem_addr;
    logic signed [DW-1:0] i_mem_data;
    logic signed [DW-1:0] o_acc_data;
    logic                 o_acc_val;
    logic [2:0]           o_acc_init;
    logic signed [DW-1:0] i_acc_data;
    logic signed [DW-1:0] o_sum;
    logic                 o_sum_val;
    logic                 i_sum_rdy;
    logic [NIW-1:0]       o_node_idx;

    modport master (
        output o_mem_rd, o_mem_addr, o_acc_data, o_acc_val, o_acc_init,
        output o_sum, o_sum_val, o_node_idx,
        input  i_mem_data, i_acc_data, i_sum_rdy
    );

    modport slave (
        input  o_mem_rd, o_mem_addr, o_acc_data, o_acc_val, o_acc_init,
        input  o_sum, o_sum_val, o_node_idx,
        output i_mem_data, i_acc_data, i_sum_rdy
    );

endinterface

// File: rtl/acc_seq_ctrl.sv
// Accumulator sequencer: fetches DEG edge messages per node, drives the accumulator
// and presents each node sum. Optional abort input enabled by ACC_SEQ_ABORT_EN.
module acc_seq_ctrl
    import ldpc_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEG   = 6,
    parameter int NODES = 8,
    parameter int AW    = $clog2(NODES * DEG),
    parameter int NIW   = idx_w(NODES)
) (
    input  logic clk,
    input  logic xrst,
    input  logic i_start,
`ifdef ACC_SEQ_ABORT_EN
    input  logic i_abort,
`endif
    output logic o_busy,
    output logic o_done,
    acc_seq_ctrl_if.master bus
);

    localparam int EW = $clog2(DEG);

    seq_state_e     state_r;
    seq_state_e     state_s;
    logic [EW-1:0]  edge_r;
    logic [EW-1:0]  edge_s;
    logic [NIW-1:0] node_r;
    logic [NIW-1:0] node_s;
    logic           rd_d_r;
    logic           init_d_r;
    logic           abort_s;
    logic           mem_rd_s;
    logic           last_edge_s;
    logic           last_node_s;

`ifdef ACC_SEQ_ABORT_EN
    assign abort_s = i_abort && (state_r != IDLE);
`else
    assign abort_s = 1'b0;
`endif

    assign mem_rd_s    = (state_r == FETCH);
    assign last_edge_s = (edge_r == EW'(DEG - 1));
    assign last_node_s = (node_r == NIW'(NODES - 1));

    // State, counters and accumulator-side delay registers.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_r  <= IDLE;
            edge_r   <= '0;
            node_r   <= '0;
            rd_d_r   <= 1'b0;
            init_d_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            edge_r   <= edge_s;
            node_r   <= node_s;
            // Abort drops any read still in flight so the accumulator sees nothing.
            rd_d_r   <= mem_rd_s && !abort_s;
            init_d_r <= mem_rd_s && (edge_r == '0) && !abort_s;
        end
    end

    // Next-state and counter advance; abort outranks every other transition.
    always_comb begin
        state_s = state_r;
        edge_s  = edge_r;
        node_s  = node_r;
        if (abort_s) begin
            state_s = IDLE;
            edge_s  = '0;
            node_s  = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        state_s = FETCH;
                        edge_s  = '0;
                        node_s  = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                FETCH: begin
                    if (last_edge_s) begin
                        state_s = TAIL;
                        edge_s  = '0;
                    end else begin
                        state_s = FETCH;
                        edge_s  = edge_r + EW'(1);
                    end
                end
                TAIL: begin
                    state_s = OUT;
                end
                OUT: begin
                    if (bus.i_sum_rdy) begin
                        if (last_node_s) begin
                            state_s = IDLE;
                            node_s  = '0;
                        end else begin
                            state_s = FETCH;
                            node_s  = node_r + NIW'(1);
                        end
                    end else begin
                        state_s = OUT;
                    end
                end
                default: begin
                    state_s = IDLE;
                    edge_s  = '0;
                    node_s  = '0;
                end
            endcase
        end
    end

    // Output decode from state and the delayed read/init flags.
    always_comb begin
        o_busy         = (state_r != IDLE);
        o_done         = 1'b0;
        bus.o_mem_rd   = mem_rd_s;
        bus.o_mem_addr = '0;
        bus.o_acc_data = bus.i_mem_data;
        bus.o_acc_val  = rd_d_r;
        bus.o_acc_init = ACC_INIT_NONE;
        bus.o_sum      = '0;
        bus.o_sum_val  = 1'b0;
        bus.o_node_idx = node_r;

        if (mem_rd_s) begin
            bus.o_mem_addr = AW'((node_r * DEG) + edge_r);
        end else begin
            bus.o_mem_addr = '0;
        end

        if (init_d_r) begin
            bus.o_acc_init = ACC_INIT_LOAD;
        end else begin
            bus.o_acc_init = ACC_INIT_NONE;
        end

        if (state_r == OUT) begin
            bus.o_sum     = bus.i_acc_data;
            bus.o_sum_val = 1'b1;
            o_done        = bus.i_sum_rdy && last_node_s && !abort_s;
        end else begin
            bus.o_sum     = '0;
            bus.o_sum_val = 1'b0;
            o_done        = 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl with a behavioural message RAM and accumulator beside it.
// Expected sums, addresses, init flags and frame timing come from a high-level model.
module tb_acc_seq_ctrl;
    import ldpc_pkg::*;

    localparam int DW    = 16;
    localparam int DEG   = 3;
    localparam int NODES = 2;
    localparam int NM    = NODES * DEG;
    localparam int AW    = $clog2(NM);
    localparam int NIW   = (NODES > 1) ? $clog2(NODES) : 1;

    logic clk = 1'b0;
    logic xrst;
    logic i_start;
    logic o_busy;
    logic o_done;
`ifdef ACC_SEQ_ABORT_EN
    logic i_abort;
`endif

    acc_seq_ctrl_if #(.DW(DW), .AW(AW), .NIW(NIW)) bus ();

    acc_seq_ctrl #(.DW(DW), .DEG(DEG), .NODES(NODES), .AW(AW), .NIW(NIW)) u_dut (
        .clk     (clk),
        .xrst    (xrst),
        .i_start (i_start),
`ifdef ACC_SEQ_ABORT_EN
        .i_abort (i_abort),
`endif
        .o_busy  (o_busy),
        .o_done  (o_done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] mem [NM];
    logic signed [DW-1:0] acc_q;

    // Message RAM: one-cycle read latency, zero when not reading.
    always @(posedge clk) begin
        if (!xrst)              bus.i_mem_data <= '0;
        else if (bus.o_mem_rd)  bus.i_mem_data <= mem[bus.o_mem_addr];
        else                    bus.i_mem_data <= '0;
    end

    // Accumulator: load on init, add otherwise, wraps at DW bits.
    always @(posedge clk) begin
        if (!xrst)             acc_q <= '0;
        else if (bus.o_acc_val) acc_q <= (bus.o_acc_init == 3'd1) ? bus.o_acc_data : acc_q + bus.o_acc_data;
    end
    assign bus.i_acc_data = acc_q;

    int tests = 0;
    int fails = 0;
    bit prev_rd = 1'b0;
    int prev_addr = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accumulator-side rule: valid/init/data follow the previous cycle's read.
    task automatic acc_obs();
        chk("acc_val", bus.o_acc_val, prev_rd);
        chk("acc_init", bus.o_acc_init, (prev_rd && (prev_addr % DEG == 0)) ? 1 : 0);
        if (prev_rd) chk("acc_data", bus.o_acc_data, mem[prev_addr]);
        prev_rd   = bus.o_mem_rd;
        prev_addr = int'(bus.o_mem_addr);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_rd"}, bus.o_mem_rd, 0);
        chk({tag, "_addr"}, bus.o_mem_addr, 0);
        chk({tag, "_accval"}, bus.o_acc_val, 0);
        chk({tag, "_accinit"}, bus.o_acc_init, 0);
        chk({tag, "_accdata"}, bus.o_acc_data, 0);
        chk({tag, "_sum"}, bus.o_sum, 0);
        chk({tag, "_sumval"}, bus.o_sum_val, 0);
        chk({tag, "_node"}, bus.o_node_idx, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            bus.i_sum_rdy = 1'b1;
            #1;
            acc_obs();
            chk("idle_busy", o_busy, 0);
            chk("idle_rd", bus.o_mem_rd, 0);
            chk("idle_sumval", bus.o_sum_val, 0);
        end
    endtask

    // kill: 0 = run to completion, 1 = reset during node 1 fetch, 2 = abort in node 0 OUT
    task automatic run_frame(input int stall, input bit spurious, input int kill);
        logic signed [DW-1:0] exp_sum [NODES];
        logic signed [DW-1:0] s;
        int hs = 0, rd_in_node = 0, dones = 0, stall_left = stall, t = 0, done_t = -1;
        bit finished = 1'b0;
        bit rdy;
        bit do_rst, do_abort;
        for (int n = 0; n < NODES; n++) begin
            s = '0;
            for (int e = 0; e < DEG; e++) s = s + mem[n * DEG + e];
            exp_sum[n] = s;
        end
        @(posedge clk); #1;
        i_start = 1'b1;
        bus.i_sum_rdy = 1'b1;
        #1;
        acc_obs();
        chk("busy_before_start", o_busy, 0);
        for (int c = 0; c < 200 && !finished; c++) begin
            @(posedge clk); #1;
            t++;
            rdy = 1'b1;
            do_rst = 1'b0;
            do_abort = 1'b0;
            if (bus.o_sum_val && hs == 0 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            i_start = spurious && ($urandom_range(0, 1) == 1);
            if (spurious && bus.o_sum_val && hs == NODES - 1 && rdy) i_start = 1'b1;
            if (kill == 1 && hs == 1 && bus.o_mem_rd) do_rst = 1'b1;
            if (kill == 2 && bus.o_sum_val && hs == 0) do_abort = 1'b1;
            bus.i_sum_rdy = rdy;
            xrst = !do_rst;
`ifdef ACC_SEQ_ABORT_EN
            i_abort = do_abort;
`endif
            #1;
            acc_obs();
            chk("busy_in_frame", o_busy, 1);
            if (bus.o_mem_rd) begin
                chk("mem_addr", bus.o_mem_addr, hs * DEG + rd_in_node);
                rd_in_node++;
            end
            if (bus.o_sum_val) begin
                chk("rd_in_out", bus.o_mem_rd, 0);
                if (hs < NODES) begin
                    chk("sum", bus.o_sum, exp_sum[hs]);
                    chk("node_idx", bus.o_node_idx, hs);
                end else begin
                    chk("extra_sum_val", bus.o_sum_val, 0);
                end
            end
            if (o_done) begin
                dones++;
                done_t = t;
                finished = 1'b1;
            end
            if (bus.o_sum_val && rdy && !do_abort) begin
                hs++;
                rd_in_node = 0;
            end
            if (do_rst) begin
                @(posedge clk); #1;
                xrst = 1'b1;
                i_start = 1'b0;
                #1;
                prev_rd = 1'b0;
                chk_all_zero("after_reset");
                chk("done_after_reset", dones, 0);
                finished = 1'b1;
            end
            if (do_abort) begin
                @(posedge clk); #1;
                i_start = 1'b0;
`ifdef ACC_SEQ_ABORT_EN
                i_abort = 1'b0;
`endif
                #1;
                acc_obs();
                chk("abort_busy", o_busy, 0);
                chk("abort_sumval", bus.o_sum_val, 0);
                chk("abort_done", o_done, 0);
                chk("done_before_abort", dones, 0);
                finished = 1'b1;
            end
        end
        chk("frame_finished", finished, 1);
        if (kill == 0) begin
            chk("done_count", dones, 1);
            chk("start_to_done", done_t, NODES * (DEG + 2) + stall);
            chk("handshakes", hs, NODES);
        end
        idle_cycles(2);
    endtask

    initial begin
        xrst = 1'b0;
        i_start = 1'b0;
        bus.i_sum_rdy = 1'b0;
`ifdef ACC_SEQ_ABORT_EN
        i_abort = 1'b0;
`endif
        for (int i = 0; i < NM; i++) mem[i] = '0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk_all_zero("reset");
        xrst = 1'b1;
        idle_cycles(2);

        // Directed frame: sums 6 and -5
        mem[0] = 16'sd1; mem[1] = 16'sd2; mem[2] = 16'sd3;
        mem[3] = -16'sd4; mem[4] = 16'sd5; mem[5] = -16'sd6;
        run_frame(0, 1'b0, 0);
        // Backpressure on node 0 for four cycles
        run_frame(4, 1'b0, 0);
        // Wrap passed through unchanged: 32767 + 1 -> -32768
        mem[0] = 16'sd32767; mem[1] = 16'sd1; mem[2] = 16'sd0;
        run_frame(0, 1'b0, 0);
        // Start pulses while busy and on the done cycle are ignored
        mem[0] = 16'sd1; mem[1] = 16'sd2; mem[2] = 16'sd3;
        run_frame(0, 1'b1, 0);
        // Reset during node 1 fetch, then a clean frame
        run_frame(0, 1'b0, 1);
        idle_cycles(1);
        run_frame(0, 1'b0, 0);
`ifdef ACC_SEQ_ABORT_EN
        run_frame(0, 1'b0, 2);
        run_frame(0, 1'b0, 0);
`endif
        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < NM; i++) mem[i] = DW'($urandom);
            if (f % 5 == 0) begin
                mem[0] = 16'sh7fff;
                mem[1] = 16'sh7fff;
            end
            run_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
            idle_cycles($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
